uart_cmd_bridge: RTL and testbench
==================================

# uart_cmd_bridge

Byte-stream command processor sitting between the `uart` receive and transmit handshake ports, in place of the loopback logic in `top`. Consumes received bytes as single-byte-opcode commands, performs 8-bit register reads and writes on a simple synchronous register bus, and returns one response byte per command to the UART transmitter. Host tools drive on-chip registers over the serial link through this block.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 1000000. Inter-byte timeout in clock cycles; range 2..2^24-1; used only with `CMD_TIMEOUT_EN`.

Ports:

- `clock` input 1: single clock for all logic.
- `reset` input 1: synchronous, active-high reset.
- `rx_byte` input 8: received byte from the UART.
- `rx_valid` input 1: `rx_byte` is valid.
- `rx_ready` output 1: the block accepts a byte. A transfer occurs on the edge where `rx_valid && rx_ready`.
- `tx_byte` output 8: response byte to the UART.
- `tx_valid` output 1: `tx_byte` is valid.
- `tx_ready` input 1: the UART accepts a byte. A transfer occurs on the edge where `tx_valid && tx_ready`.
- `bus_addr` output 8: register address.
- `bus_wdata` output 8: write data.
- `bus_we` output 1: one-cycle write strobe.
- `bus_re` output 1: one-cycle read strobe.
- `bus_rdata` input 8: read data, valid exactly one cycle after `bus_re`.
- `err_count` output 8: saturating count of rejected commands.

## Operation

- All outputs are registered. Reset values: `rx_ready`=0, `tx_valid`=0, `tx_byte`=0, `bus_we`=0, `bus_re`=0, `bus_addr`=0, `bus_wdata`=0, `err_count`=0. State resets to IDLE.
- `rx_ready` is 1 only in IDLE, GET_ADDR and GET_DATA. It rises on the first edge with `reset` low.
- IDLE: accept an opcode byte.
  - 0x57 ('W'): go to GET_ADDR, write flavour.
  - 0x52 ('R'): go to GET_ADDR, read flavour.
  - Any other value: load `tx_byte`=0x3F ('?'), increment `err_count`, go to SEND.
- GET_ADDR: accept a byte into `bus_addr`.
  - Write flavour: go to GET_DATA.
  - Read flavour: go to READ.
- GET_DATA: accept a byte into `bus_wdata`. Go to WRITE.
- WRITE: `bus_we`=1 for exactly this cycle. Load `tx_byte`=0x4B ('K') and go to SEND.
- READ: `bus_re`=1 for exactly this cycle. Go to RD_WAIT.
- RD_WAIT: sample `bus_rdata` into `tx_byte`. Go to SEND.
- SEND: `tx_valid`=1 and `tx_byte` are held stable until the edge where `tx_ready`=1. On that edge, clear `tx_valid` and return to IDLE.
- `bus_addr` and `bus_wdata` hold their last values between commands.
- `err_count` saturates at 0xFF.
- A `reset` assertion in any state returns the block to IDLE with reset values on the next edge. A partially received command is discarded, and any pending response is dropped.

## Timing

- Write: third byte accepted on edge N. `bus_we` is high during cycle N..N+1. `tx_valid` is high from edge N+1. Earliest response transfer is on edge N+2.
- Read: address byte accepted on edge N. `bus_re` is high during cycle N..N+1. `bus_rdata` is sampled on edge N+2 and `tx_valid` rises on edge N+2.
- Unknown opcode: accepted on edge N; `tx_valid` is high from edge N.
- Throughput: at most one command in flight. `rx_ready` stays low from the last command byte until the response transfer completes. Back-pressure on `tx_ready` stalls indefinitely, with no byte loss.
- `bus_we` and `bus_re` are never high in the same cycle, and never high for more than one cycle per command.

## Configuration

- `CMD_TIMEOUT_EN` defined: a 24-bit counter clears on every accepted byte and counts in GET_ADDR and GET_DATA. When it reaches `TIMEOUT_CYCLES`-1 with no byte accepted:
  - abort to IDLE on the next edge;
  - increment `err_count`;
  - issue no bus access and send no response.
  
  If a byte is accepted on the same edge as the timeout, the byte wins.
- `CMD_TIMEOUT_EN` undefined: there is no counter, `TIMEOUT_CYCLES` is ignored, and a partial command waits forever.

## Test plan

- Write: bytes 0x57, 0x10, 0xA5 with `tx_ready`=1 -> one `bus_we` pulse with `bus_addr`=0x10 and `bus_wdata`=0xA5; response 0x4B; `rx_ready` returns to 1.
- Read: bus model returns 0x3C at address 0x22; bytes 0x52, 0x22 -> one `bus_re` pulse with `bus_addr`=0x22; response 0x3C, `tx_valid` rising two edges after the address byte.
- Unknown opcode 0x00 sent 300 times -> each returns 0x3F; `err_count` reaches 0xFF and stays there; no bus strobes.
- Back-pressure: `tx_ready` held 0 for 50 cycles during a read -> `tx_valid` and `tx_byte` remain stable and `rx_ready` remains 0; a single transfer occurs when `tx_ready` rises.
- Reset mid-command: after 0x57, 0x10, assert `reset` for 1 cycle, then send 0xA5 -> no `bus_we`; 0xA5 is treated as an opcode and the response is 0x3F.
- With `CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: send 0x57, then idle 20 cycles -> return to IDLE, `err_count`=1, no response; a following full write command completes normally.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: turns a UART byte stream into 8-bit register-bus
// reads/writes. Commands: 'W' addr data -> 'K'; 'R' addr -> data;
// anything else -> '?' plus an error count bump. One command in flight.
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout that aborts
// a partially received command after TIMEOUT_CYCLES of silence).
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_WRITE, S_READ, S_RD_WAIT, S_SEND
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'hFF_FFFF) begin : g_bad_timeout
    $error("uart_cmd_bridge: TIMEOUT_CYCLES out of range 2..2^24-1");
  end

  state_t     r_state, w_state_nx;
  logic       r_is_wr, w_is_wr_nx;
  logic       r_rx_ready, r_tx_valid, w_tx_valid_nx;
  logic [7:0] r_tx_byte, w_tx_byte_nx;
  logic [7:0] r_addr, w_addr_nx, r_wdata, w_wdata_nx;
  logic       r_we, r_re;
  logic [7:0] r_err;
  logic       w_err_inc, w_acc, w_timeout;

  // a byte moves only when we already advertised ready
  assign w_acc = rx_valid && r_rx_ready;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] r_to_cnt;

  assign w_timeout = (r_state == S_GET_ADDR || r_state == S_GET_DATA) && !w_acc &&
                     (r_to_cnt == 24'(TIMEOUT_CYCLES - 1));

  // idle-time counter while waiting for the rest of a command
  always_ff @(posedge clock) begin
    if (reset || w_acc || !(r_state == S_GET_ADDR || r_state == S_GET_DATA))
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 24'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // next-state and next-output-register values
  always_comb begin
    w_state_nx    = r_state;
    w_is_wr_nx    = r_is_wr;
    w_addr_nx     = r_addr;
    w_wdata_nx    = r_wdata;
    w_tx_byte_nx  = r_tx_byte;
    w_tx_valid_nx = r_tx_valid;
    w_err_inc     = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) begin
        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
          w_is_wr_nx = (rx_byte == OP_WRITE);
          w_state_nx = S_GET_ADDR;
        end else begin
          w_tx_byte_nx  = RSP_BAD;
          w_tx_valid_nx = 1'b1;
          w_err_inc     = 1'b1;
          w_state_nx    = S_SEND;
        end
      end
      S_GET_ADDR: if (w_acc) begin
        w_addr_nx  = rx_byte;
        w_state_nx = r_is_wr ? S_GET_DATA : S_READ;
      end else if (w_timeout) begin
        w_err_inc  = 1'b1;
        w_state_nx = S_IDLE;
      end
      S_GET_DATA: if (w_acc) begin
        w_wdata_nx = rx_byte;
        w_state_nx = S_WRITE;
      end else if (w_timeout) begin
        w_err_inc  = 1'b1;
        w_state_nx = S_IDLE;
      end
      S_WRITE: begin
        w_tx_byte_nx  = RSP_OK;
        w_tx_valid_nx = 1'b1;
        w_state_nx    = S_SEND;
      end
      S_READ: w_state_nx = S_RD_WAIT;
      S_RD_WAIT: begin
        w_tx_byte_nx  = bus_rdata;
        w_tx_valid_nx = 1'b1;
        w_state_nx    = S_SEND;
      end
      S_SEND: if (tx_ready) begin
        w_tx_valid_nx = 1'b0;
        w_state_nx    = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // state and registered outputs; strobes/ready derive from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_rx_ready <= 1'b0;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_is_wr    <= w_is_wr_nx;
      r_rx_ready <= (w_state_nx == S_IDLE) || (w_state_nx == S_GET_ADDR) ||
                    (w_state_nx == S_GET_DATA);
      r_tx_byte  <= w_tx_byte_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_addr     <= w_addr_nx;
      r_wdata    <= w_wdata_nx;
      r_we       <= (w_state_nx == S_WRITE);
      r_re       <= (w_state_nx == S_READ);
      if (w_err_inc && r_err != 8'hFF)
        r_err <= r_err + 8'd1;
    end
  end

  assign rx_ready  = r_rx_ready;
  assign tx_byte   = r_tx_byte;
  assign tx_valid  = r_tx_valid;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_we    = r_we;
  assign bus_re    = r_re;
  assign err_count = r_err;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: command-level reference model (byte queues,
// expected bus-op and response queues, register image), a per-cycle
// compare process, a randomized response consumer, and directed cases.
module tb_uart_cmd_bridge;
  logic       clock = 0, reset = 1;
  logic [7:0] rx_byte = 0;
  logic       rx_valid = 0, rx_ready;
  logic [7:0] tx_byte;
  logic       tx_valid, tx_ready;
  logic [7:0] bus_addr, bus_wdata, bus_rdata = 0;
  logic       bus_we, bus_re;
  logic [7:0] err_count;

  uart_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .err_count(err_count));

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++; n_err++;
    $display("FAIL %s", name);
  endtask

  // register slave: read data valid one cycle after the read strobe
  logic [7:0] slave_mem [256];
  always @(posedge clock) begin
    if (bus_we) slave_mem[bus_addr] <= bus_wdata;
    if (bus_re) bus_rdata <= slave_mem[bus_addr];
  end

  // reference model state
  logic [7:0]  ref_mem [256];
  logic [7:0]  cur[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] exp_wr[$];
  int          model_err = 0;
  bit          pending = 0, chk_en = 0, bp_hold = 0;

  task automatic model_accept(input logic [7:0] b);
    if (cur.size() == 0) begin
      if (b == 8'h57 || b == 8'h52) cur.push_back(b);
      else begin
        exp_tx.push_back(8'h3F);
        if (model_err < 255) model_err++;
        pending = 1;
      end
    end else if (cur[0] == 8'h52) begin
      exp_rd.push_back(b);
      exp_tx.push_back(ref_mem[b]);
      cur.delete(); pending = 1;
    end else if (cur.size() == 1) begin
      cur.push_back(b);
    end else begin
      exp_wr.push_back({cur[1], b});
      ref_mem[cur[1]] = b;
      exp_tx.push_back(8'h4B);
      cur.delete(); pending = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    rx_byte = b; rx_valid = 1;
    while (!rx_ready && n < 300) begin @(negedge clock); n++; end
    if (!rx_ready) begin flag("rx_accept_timeout"); rx_valid = 0; return; end
    @(posedge clock); #1;
    rx_valid = 0;
    model_accept(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending && n < 500) begin @(negedge clock); n++; end
    if (pending) flag("response_timeout");
  endtask

  task automatic do_reset(input int cycles);
    chk_en = 0;
    @(negedge clock);
    reset = 1; rx_valid = 0;
    repeat (cycles) @(negedge clock);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_strobes", {bus_we, bus_re}, 0);
    chk("rst_addr_wdata", {bus_addr, bus_wdata}, 0);
    chk("rst_err", err_count, 0);
    reset = 0;
    cur.delete(); exp_tx.delete(); exp_rd.delete(); exp_wr.delete();
    pending = 0; model_err = 0;
    @(negedge clock);
    chk("rx_ready_rise", rx_ready, 1);
    chk_en = 1;
  endtask

  // per-cycle compare against the model
  initial forever begin
    @(negedge clock);
    if (chk_en && !reset) begin
      chk("err_count", err_count, model_err);
      chk("rx_ready", rx_ready, !pending);
      if (bus_we && bus_re) flag("we_re_overlap");
      if (bus_we) begin
        if (exp_wr.size() == 0) flag("unexpected_bus_we");
        else chk("bus_write", {bus_addr, bus_wdata}, exp_wr.pop_front());
      end
      if (bus_re) begin
        if (exp_rd.size() == 0) flag("unexpected_bus_re");
        else chk("bus_read_addr", bus_addr, exp_rd.pop_front());
      end
    end
  end

  // response consumer with random back-pressure and stability check
  initial begin
    bit v_l = 0, r_l = 0;
    logic [7:0] b_l = 0;
    tx_ready = 0;
    forever begin
      @(negedge clock);
      if (reset || !chk_en) begin v_l = 0; tx_ready = 0; continue; end
      if (v_l && !r_l) chk("tx_hold", {tx_valid, tx_byte}, {1'b1, b_l});
      tx_ready = bp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      v_l = tx_valid; b_l = tx_byte; r_l = tx_ready;
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) flag("unexpected_tx");
        else chk("tx_byte", tx_byte, exp_tx.pop_front());
        @(posedge clock); #1;
        pending = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[8'h22] = 8'h3C; ref_mem[8'h22] = 8'h3C;
    repeat (2) @(negedge clock);
    do_reset(3);

    // directed write: strobe one cycle after the data byte, 'K' one later
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    @(negedge clock);
    chk("wr_strobe", {bus_we, bus_addr, bus_wdata}, {1'b1, 8'h10, 8'hA5});
    chk("wr_tx_early", tx_valid, 0);
    @(negedge clock);
    chk("wr_resp", {tx_valid, tx_byte, bus_we}, {1'b1, 8'h4B, 1'b0});
    wait_idle();

    // directed read: response two edges after the address byte
    send_byte(8'h52); send_byte(8'h22);
    @(negedge clock);
    chk("rd_strobe", {bus_re, bus_addr, tx_valid}, {1'b1, 8'h22, 1'b0});
    @(negedge clock);
    chk("rd_wait", {bus_re, tx_valid}, 0);
    @(negedge clock);
    chk("rd_resp", {tx_valid, tx_byte}, {1'b1, 8'h3C});
    wait_idle();

    // back-pressure during a read
    bp_hold = 1;
    send_byte(8'h52); send_byte(8'h05);
    repeat (50) @(negedge clock);
    chk("bp_held", {tx_valid, rx_ready, tx_byte}, {1'b1, 1'b0, ref_mem[8'h05]});
    bp_hold = 0;
    wait_idle();

    // randomized commands with random gaps and random tx_ready
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 9);
      logic [7:0] op;
      if (r < 4) begin
        send_byte(8'h57); send_byte(8'($urandom_range(0, 15))); send_byte(8'($urandom));
      end else if (r < 8) begin
        send_byte(8'h52); send_byte(8'($urandom_range(0, 15)));
      end else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
        send_byte(op);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle();

    // reset mid-command: partial write discarded, next byte is an opcode
    send_byte(8'h57); send_byte(8'h10);
    do_reset(1);
    send_byte(8'hA5);
    @(negedge clock);
    chk("rst_mid_resp", {tx_valid, tx_byte}, {1'b1, 8'h3F});
    wait_idle();
    chk("rst_mid_err", err_count, 1);

`ifdef CMD_TIMEOUT_EN
    // timeout: abandoned 'W' aborts silently with one error
    send_byte(8'h57);
    chk_en = 0;
    repeat (20) @(negedge clock);
    cur.delete();
    model_err++;
    chk("to_err", err_count, 2);
    chk("to_idle", {rx_ready, tx_valid}, {1'b1, 1'b0});
    chk_en = 1;
    send_byte(8'h57); send_byte(8'h33); send_byte(8'h99);
    wait_idle();
`endif

    // 300 unknown opcodes: error count saturates
    for (int i = 0; i < 300; i++) send_byte(8'h00);
    wait_idle();
    chk("err_sat", err_count, 8'hFF);
    repeat (3) @(negedge clock);
    chk("queues_empty", exp_tx.size() + exp_rd.size() + exp_wr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
